mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001: The module SHALL have parameter LATENCY, default 3, meaning clock cycles from request acceptance to mem_resp (legal range 1..15).
REQ-002: The module SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of backing storage (power of two).
REQ-003: clk  input  1  the single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-low reset.
REQ-005: mem_read  input  1  initiator read request, held until mem_resp.
REQ-006: mem_write  input  1  initiator write request, held until mem_resp.
REQ-007: mem_byte_enable  input  4  write byte-lane mask; bit i enables mem_wdata[8i+7:8i].
REQ-008: mem_address  input  32  byte address; bits [1:0] are ignored.
REQ-009: mem_wdata  input  32  write data, already lane-aligned by the initiator.
REQ-010: mem_resp  output  1  one-cycle completion pulse.
REQ-011: mem_rdata  output  32  read data, valid only while mem_resp=1, else 0.
REQ-012: mem_error  output  1  one-cycle pulse coincident with mem_resp for an illegal request.

Function
REQ-013: FSM states SHALL be IDLE, WAIT, RESP.
REQ-014: In IDLE, mem_read|mem_write SHALL accept the request on that edge: capture address, wdata, byte_enable, and op; load the counter with LATENCY-1.
REQ-015: If LATENCY=1, acceptance SHALL go IDLE->RESP directly; otherwise IDLE->WAIT.
REQ-016: WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 1.
REQ-017: mem_resp SHALL be 1 exactly in RESP, i.e. LATENCY cycles after the acceptance edge; RESP SHALL always go to IDLE.
REQ-018: Requests in WAIT and RESP SHALL be ignored; only the captured values are used, and input changes after acceptance have no effect.
REQ-019: A request present in the cycle immediately after RESP SHALL be accepted, giving back-to-back throughput of one request per LATENCY+1 cycles.
REQ-020: Word index SHALL be captured address[31:2]; an index >= DEPTH_WORDS SHALL be illegal.
REQ-021: mem_read and mem_write asserted together SHALL be illegal.
REQ-022: Illegal requests SHALL follow the same timing, assert mem_error with mem_resp, return mem_rdata=0, and leave storage unmodified.
REQ-023: A legal write SHALL commit the enabled byte lanes on the edge entering RESP; disabled lanes are unchanged; mbe=0000 is a legal no-op.
REQ-024: A legal read SHALL return the full word as of the edge entering RESP, including a write committed by the immediately preceding request.
REQ-025: mem_rdata SHALL be registered; it SHALL be 0 in IDLE and WAIT.

Reset
REQ-026: When rst=0, the module SHALL asynchronously force state=IDLE, counter=0, mem_resp=0, mem_error=0, mem_rdata=0, and clear the captured registers.
REQ-027: Reset during WAIT SHALL abort the request with no storage write and no mem_resp.
REQ-028: Storage contents SHALL NOT be reset.
REQ-029: The first request SHALL be accepted on the first rising edge with rst=1.

Structure
REQ-030: The state enum (mem_resp_state_t: IDLE, WAIT, RESP) SHALL live in the shared rv32i_types package.
REQ-031: Storage SHALL be one sub-module, mem_byte_ram: synchronous, with a 4-bit byte-write mask, DEPTH_WORDS deep, and one read/write port.
REQ-032: The FSM, counter, and legality check SHALL reside in mem_responder.

Verification
REQ-033: LATENCY=3: write addr 0x10, data 0xDEADBEEF, mbe 1111 -> mem_resp exactly 3 cycles after accept, mem_error=0; then read 0x10 -> mem_rdata=0xDEADBEEF.
REQ-034: Word 0x20=0x11223344; write 0x000000AA with mbe 0001 -> read 0x20 returns 0x112233AA; read of address 0x23 also returns 0x112233AA.
REQ-035: LATENCY=1: back-to-back reads of 0x0 and 0x4 -> mem_resp pulses 2 cycles apart; mem_rdata=0 between pulses.
REQ-036: DEPTH_WORDS=256: read 0x400 -> mem_resp=1, mem_error=1, mem_rdata=0; mem_read=mem_write=1 at 0x8 -> error, word 0x8 unchanged.
REQ-037: Write 0x55 to 0x30 with rst pulsed low during WAIT -> no mem_resp; a later read of 0x30 returns its prior value.
REQ-038: Change mem_address from 0x40 to 0x44 one cycle after accepting a write -> only word 0x40 is modified.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the memory responder
package rv32i_types;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_byte_ram.sv
// mem_byte_ram: word-addressed storage with byte-lane write mask and a registered read port
module mem_byte_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_re,
  input  logic [3:0]                     i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
  // Read data is only non-zero for the single cycle following a read strobe.
  always_ff @(posedge clk or negedge rst)
    if (!rst) o_rdata <= '0;
    else o_rdata <= i_re ? r_mem[i_addr] : '0;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory target with request capture, legality check and byte-lane writes
module mem_responder
  import rv32i_types::*;
#(
  parameter int LATENCY     = 3,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  mem_resp_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [29:0]      r_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic             r_rd, r_wr;
  logic             w_idle, w_req, w_rd, w_wr, w_legal, w_fire, w_unused;
  logic [29:0]      w_idx;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;
  assign w_unused = ^mem_address[1:0];
  assign w_idle   = r_state == IDLE;
  assign w_req    = mem_read | mem_write;
  // With LATENCY=1 the RAM access happens on the acceptance edge, so use live inputs while idle.
  assign w_idx    = w_idle ? mem_address[31:2] : r_idx;
  assign w_wdata  = w_idle ? mem_wdata : r_wdata;
  assign w_be     = w_idle ? mem_byte_enable : r_be;
  assign w_rd     = w_idle ? mem_read : r_rd;
  assign w_wr     = w_idle ? mem_write : r_wr;
  assign w_legal  = !(w_rd && w_wr) && (w_idx < 30'(DEPTH_WORDS));
  assign w_fire   = w_idle ? w_req && (LATENCY == 1) : (r_state == WAIT) && (r_cnt == CNT_W'(1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      mem_resp  <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      mem_resp  <= w_fire;
      mem_error <= w_fire && !w_legal;
      case (r_state)
        IDLE: if (w_req) begin
          r_state <= (LATENCY == 1) ? RESP : WAIT;
          r_cnt   <= CNT_W'(LATENCY - 1);
          r_idx   <= mem_address[31:2];
          r_wdata <= mem_wdata;
          r_be    <= mem_byte_enable;
          r_rd    <= mem_read;
          r_wr    <= mem_write;
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  mem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_re    (w_fire && w_legal && w_rd),
    .i_we    ({4{w_fire && w_legal && w_wr}} & w_be),
    .i_addr  (w_idx[AW-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (mem_rdata)
  );
endmodule
